// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Build option: define REGFILE_BYPASS_EN for same-edge write-to-read forwarding.
package regfile_pkg;

    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned DEPTH_DEF = 32;
    localparam int unsigned NR_DEF    = 2;
    localparam int unsigned NW_DEF    = 1;
    localparam int unsigned AW_DEF    = $clog2(DEPTH_DEF);

    // Hardwired-zero register index
    localparam int unsigned ZERO_REG  = 0;

    // One writeback request at the default geometry
    typedef struct packed {
        logic                en;
        logic [AW_DEF-1:0]   addr;
        logic [DW_DEF-1:0]   data;
    } regfile_wr_t;

endpackage

// File: rtl/regfile_sb.sv
// Pending-write scoreboard: one bit per register, set beats clear, r0 never pending.
// Build option: REGFILE_BYPASS_EN selects the post-update view on sb_view_c.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic [DEPTH-1:0] wr_clr,
    output logic [DEPTH-1:0] sb_view_c,
    output logic             sb_any
);

    logic [DEPTH-1:0] sb_q;
    logic [DEPTH-1:0] sb_nxt;

    // Clear on accepted writes, then set so a newly issued producer wins
    always_comb begin
        sb_nxt = sb_q & ~wr_clr;
        if (sb_set && (sb_addr != AW'(ZERO_REG))) begin
            sb_nxt[sb_addr] = 1'b1;
        end
        sb_nxt[AW'(ZERO_REG)] = 1'b0;
    end

    // Scoreboard bits and the lagged any-pending flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q   <= '0;
            sb_any <= 1'b0;
        end else begin
            sb_q   <= sb_nxt;
            sb_any <= |sb_q;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign sb_view_c = sb_nxt;
`else
    assign sb_view_c = sb_q;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NW write ports (highest index wins), NR registered
// read ports, per-register pending scoreboard.
// Build option: REGFILE_BYPASS_EN forwards same-edge write data and busy state.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned NR    = NR_DEF,
    parameter int unsigned NW    = NW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_busy,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NW*DW-1:0] wr_data,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    output logic             sb_any
);

    logic [DW-1:0]    mem_q   [DEPTH];
    logic [DW-1:0]    mem_nxt [DEPTH];
    logic [DEPTH-1:0] wr_hit_c;
    logic [DEPTH-1:0] sb_view_c;
    logic [NR*DW-1:0] rd_data_nxt;
    logic [NR-1:0]    rd_busy_nxt;

    // Write arbitration: ascending port order so the highest port lands last
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            mem_nxt[r] = mem_q[r];
        end
        wr_hit_c = '0;
        for (int w = 0; w < NW; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != AW'(ZERO_REG))) begin
                mem_nxt[wr_addr[w*AW +: AW]]  = wr_data[w*DW +: DW];
                wr_hit_c[wr_addr[w*AW +: AW]] = 1'b1;
            end
        end
    end

    // Register storage; r0 is never written so it holds its reset zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= mem_nxt[r];
            end
        end
    end

    regfile_sb #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .wr_clr    (wr_hit_c),
        .sb_view_c (sb_view_c),
        .sb_any    (sb_any)
    );

    // Read muxes with optional same-edge forwarding from the write ports
    always_comb begin
        rd_data_nxt = '0;
        rd_busy_nxt = '0;
        for (int i = 0; i < NR; i++) begin
            rd_data_nxt[i*DW +: DW] = mem_q[rd_addr[i*AW +: AW]];
            rd_busy_nxt[i]          = sb_view_c[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NW; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != AW'(ZERO_REG)) &&
                    (wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW])) begin
                    rd_data_nxt[i*DW +: DW] = wr_data[w*DW +: DW];
                end
            end
`endif
        end
    end

    // Registered read outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            rd_data <= rd_data_nxt;
            rd_busy <= rd_busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp at NR=4, NW=2 with a behavioural reference model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int NW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             sb_any;

    typedef struct packed {
        logic [NR*AW-1:0] ra;
        logic [NW-1:0]    we;
        logic [NW*AW-1:0] wa;
        logic [NW*DW-1:0] wd;
        logic             ss;
        logic [AW-1:0]    sa;
    } stim_t;

    typedef struct packed {
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    busy;
        logic             any;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_busy [DEPTH];
    int            n_chk  = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;

    regfile_mp #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .NR    (NR),
        .NW    (NW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .sb_any  (sb_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    // Apply one cycle of stimulus at a falling edge, queue what the next rising edge must show
    task automatic step(input stim_t s);
        exp_t          e;
        logic [DW-1:0] nreg  [DEPTH];
        bit            nbusy [DEPTH];
        logic [AW-1:0] a;
        logic [AW-1:0] wa;
        rd_addr = s.ra;
        wr_en   = s.we;
        wr_addr = s.wa;
        wr_data = s.wd;
        sb_set  = s.ss;
        sb_addr = s.sa;
        nreg  = m_reg;
        nbusy = m_busy;
        for (int w = 0; w < NW; w++) begin
            wa = s.wa[w*AW +: AW];
            if (s.we[w] && wa != 0) begin
                nreg[wa]  = s.wd[w*DW +: DW];
                nbusy[wa] = 1'b0;
            end
        end
        if (s.ss && s.sa != 0) nbusy[s.sa] = 1'b1;
        e.any = 1'b0;
        for (int r = 0; r < DEPTH; r++) e.any = e.any | m_busy[r];
        for (int i = 0; i < NR; i++) begin
            a = s.ra[i*AW +: AW];
            e.data[i*DW +: DW] = m_reg[a];
            e.busy[i]          = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NW; w++) begin
                wa = s.wa[w*AW +: AW];
                if (s.we[w] && wa != 0 && wa == a) e.data[i*DW +: DW] = s.wd[w*DW +: DW];
            end
            e.busy[i] = nbusy[a];
`endif
        end
        q.push_back(e);
        m_reg  = nreg;
        m_busy = nbusy;
        @(negedge clk);
    endtask

    // Monitor: every rising edge produces one set of outputs to compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_busy", (NR*DW)'(rd_busy), (NR*DW)'(e.busy));
                chk("sb_any", (NR*DW)'(sb_any), (NR*DW)'(e.any));
            end
        end
    end

    initial begin
        stim_t s;
        rd_addr = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
        model_reset();

        #1 rst = 1'b0;
        #1;
        chk("reset_rd_data", rd_data, '0);
        chk("reset_rd_busy", (NR*DW)'(rd_busy), '0);
        chk("reset_sb_any", (NR*DW)'(sb_any), '0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Zero register: write and mark pending are both dropped
        s = idle();
        s.we = 2'b01; s.wa[0 +: AW] = 5'd0; s.wd[0 +: DW] = 32'h12345678;
        s.ss = 1'b1; s.sa = 5'd0;
        step(s);
        s = idle();
        step(s);
        chk("r0_data", (NR*DW)'(rd_data[0 +: DW]), '0);
        chk("r0_busy", (NR*DW)'(rd_busy[0]), '0);
        chk("r0_sb_any", (NR*DW)'(sb_any), '0);

        // Write conflict: port 1 wins
        s = idle();
        s.we = 2'b11;
        s.wa[0 +: AW] = 5'd7; s.wd[0 +: DW]  = 32'hAAAA0000;
        s.wa[AW +: AW] = 5'd7; s.wd[DW +: DW] = 32'h5555FFFF;
        step(s);
        s = idle();
        s.ra[AW +: AW] = 5'd7;
        step(s);
        chk("conflict_r7", (NR*DW)'(rd_data[DW +: DW]), (NR*DW)'(32'h5555FFFF));

        // Scoreboard: set beats a same-edge clear
        s = idle(); s.ss = 1'b1; s.sa = 5'd3; s.ra[0 +: AW] = 5'd3;
        step(s);
        s.we = 2'b01; s.wa[0 +: AW] = 5'd3; s.wd[0 +: DW] = 32'h33;
        step(s);
        s = idle(); s.ra[0 +: AW] = 5'd3;
        step(s);
        chk("sb_busy_held", (NR*DW)'(rd_busy[0]), (NR*DW)'(1'b1));
        chk("sb_any_held", (NR*DW)'(sb_any), (NR*DW)'(1'b1));
        s.we = 2'b01; s.wa[0 +: AW] = 5'd3; s.wd[0 +: DW] = 32'h34;
        step(s);
        s = idle(); s.ra[0 +: AW] = 5'd3;
        step(s);
        step(s);
        chk("sb_busy_cleared", (NR*DW)'(rd_busy[0]), '0);
        chk("sb_any_cleared", (NR*DW)'(sb_any), '0);

        // Same-edge read and write of r9
        s = idle(); s.we = 2'b01; s.wa[0 +: AW] = 5'd9; s.wd[0 +: DW] = 32'h11;
        step(s);
        s.wd[0 +: DW] = 32'h42; s.ra[2*AW +: AW] = 5'd9;
        step(s);
`ifdef REGFILE_BYPASS_EN
        chk("same_edge_r9", (NR*DW)'(rd_data[2*DW +: DW]), (NR*DW)'(32'h42));
`else
        chk("same_edge_r9", (NR*DW)'(rd_data[2*DW +: DW]), (NR*DW)'(32'h11));
`endif

        // Port independence across four read ports
        s = idle(); s.we = 2'b11;
        s.wa[0 +: AW] = 5'd1; s.wd[0 +: DW] = 32'd1;
        s.wa[AW +: AW] = 5'd2; s.wd[DW +: DW] = 32'd2;
        step(s);
        s = idle(); s.we = 2'b01; s.wa[0 +: AW] = 5'd3; s.wd[0 +: DW] = 32'd3;
        step(s);
        s = idle();
        s.ra = {5'd0, 5'd3, 5'd2, 5'd1};
        step(s);
        chk("four_ports", rd_data, {32'd0, 32'd3, 32'd2, 32'd1});

        // Randomised traffic with biased addresses to provoke collisions
        for (int n = 0; n < 400; n++) begin
            s = idle();
            for (int i = 0; i < NR; i++) s.ra[i*AW +: AW] = rnd_addr();
            for (int w = 0; w < NW; w++) begin
                s.we[w]            = 1'($urandom_range(0, 1));
                s.wa[w*AW +: AW]   = rnd_addr();
                s.wd[w*DW +: DW]   = $urandom;
            end
            s.ss = ($urandom_range(0, 2) == 0);
            s.sa = rnd_addr();
            step(s);
        end

        // Reset mid-cycle after a write: write is lost, outputs clear at once
        s = idle(); s.ss = 1'b1; s.sa = 5'd6;
        step(s);
        s = idle(); s.ss = 1'b1; s.sa = 5'd6; s.ra[0 +: AW] = 5'd6;
        s.we = 2'b01; s.wa[0 +: AW] = 5'd5; s.wd[0 +: DW] = 32'hDEADBEEF;
        step(s);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midreset_rd_data", rd_data, '0);
        chk("midreset_rd_busy", (NR*DW)'(rd_busy), '0);
        chk("midreset_sb_any", (NR*DW)'(sb_any), '0);
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd4; wr_data[0 +: DW] = 32'hABC;
        sb_set = 1'b1; sb_addr = 5'd4; rd_addr = {5'd0, 5'd0, 5'd4, 5'd5};
        repeat (2) @(posedge clk);
        #1;
        chk("held_rd_data", rd_data, '0);
        chk("held_sb_any", (NR*DW)'(sb_any), '0);
        @(negedge clk);
        q.delete();
        model_reset();
        rst    = 1'b1;
        mon_en = 1'b1;
        s = idle(); s.ra = {5'd0, 5'd0, 5'd4, 5'd5};
        step(s);
        chk("r5_after_reset", (NR*DW)'(rd_data[0 +: DW]), '0);
        chk("r4_after_reset", (NR*DW)'(rd_data[DW +: DW]), '0);
        s = idle();
        step(s);

        chk("queue_drained", (NR*DW)'(q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register pending-write scoreboard and registered read ports. It is the core's architectural register storage and sits between decode, which reads operands and marks destinations pending, and writeback, which retires results. It generalises the single-write/dual-read file to NR read ports and NW write ports with defined write-conflict priority and one-cycle read latency. Read-after-write forwarding is an optional build feature.

## Interface
- DW, 32: data width in bits
- DEPTH, 32: number of registers; power of two, at least 2
- AW, $clog2(DEPTH): address width; derived, do not override
- NR, 2: read ports, 1..4
- NW, 1: write ports, 1..2
- clk  in  1: rising-edge clock, sole clock
- rst  in  1: reset, asynchronous, active-low
- rd_addr  in  NR*AW: read addresses, port i at [i*AW +: AW]
- rd_data  out  NR*DW: registered read data, port i at [i*DW +: DW]
- rd_busy  out  NR: registered scoreboard bit of the register addressed on port i
- wr_en  in  NW: write strobes
- wr_addr  in  NW*AW: write addresses
- wr_data  in  NW*DW: write data
- sb_set  in  1: mark register sb_addr pending
- sb_addr  in  AW: register to mark pending
- sb_any  out  1: OR of all scoreboard bits, registered

## Operation
- Register 0 is hardwired zero. Writes to it are dropped, and it can never become pending. Reads of it return 0 and busy 0.
- Write: on each rising edge, every port with wr_en=1 and a nonzero address updates its register.
- Write conflict: when two ports write the same address in one cycle, the higher port index wins.
- Scoreboard: one bit per register.
  - sb_set=1 sets bit sb_addr.
  - Any accepted write clears the bit for its address.
  - Set and clear of the same address in the same cycle: set wins, because a new producer has been issued.
  - sb_set to address 0 is ignored.
- Read: each port samples rd_addr at the edge. rd_data and rd_busy present the value at the next edge.
- Reset (rst=0, asynchronous): all registers, scoreboard bits, rd_data, rd_busy and sb_any go to 0 immediately. Writes and sb_set are ignored while rst=0.
- Release: the first edge with rst=1 is a normal operating edge.
- Reset asserted mid-write: the write is lost and the register reads 0.

## Timing
- Read latency is 1 cycle from address to rd_data.
- A write at edge N is visible to an address sampled at edge N+1.
- Same-edge read and write to the same address:
  - Without bypass, rd_data returns the pre-write value.
  - With bypass, see Configuration.
- rd_busy reflects scoreboard state before the sampling edge's set/clear updates, because its value is registered.
- sb_any is updated with the same one-edge lag.
- No handshakes and no stalls. All inputs are accepted every cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address matches an enabled, nonzero write address at the same edge returns that write's data. On multiple matches, the highest write port wins.
  - rd_busy for that port returns the post-update scoreboard bit.
- REGFILE_BYPASS_EN undefined: no forwarding. Same-edge reads return old data and old busy state.

## Structure
- Shared package regfile_pkg holds:
  - default DW, DEPTH, NR and NW constants
  - the ZERO_REG address constant
  - a regfile_wr_t struct of en, addr and data, used by writeback
- Sub-module regfile_sb holds the scoreboard bit vector and its set/clear priority logic. The top module holds storage, write arbitration, read muxes and bypass.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst low mid-cycle -> rd_data, rd_busy and sb_any are 0 immediately. A read of r5 after release returns 0x00000000.
- Zero register: write 0x12345678 to r0 with sb_set on r0 -> a read of r0 returns 0 and busy 0, and sb_any stays 0.
- Write conflict (NW=2): both ports write r7, port0 0xAAAA0000 and port1 0x5555FFFF -> the next read of r7 returns 0x5555FFFF.
- Scoreboard: sb_set r3, then the next cycle sb_set r3 and a write of r3 together -> rd_busy on r3 stays 1 and sb_any stays 1. A later write-only of r3 clears busy and sb_any.
- Same-edge read and write of r9 = 0x00000042, old value 0x11 -> rd_data is 0x00000042 with REGFILE_BYPASS_EN and 0x00000011 without it.
- Port independence (NR=4): read r1, r2, r3 and r0 simultaneously after loading 1, 2 and 3 -> rd_data is {0, 3, 2, 1} from port 3 down to port 0, one cycle later.
